// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_sel_arbiter: 4-channel round-robin arbiter driving a 4:1 mux select.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam bit             c_TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;
  logic [3:0]       r_grant;
  logic [3:0]       w_grant_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;
  logic [1:0]       w_pick;
  logic             w_found;

  // Search starts just after the last served channel, so it gets lowest priority.
  always_comb begin : p_pick
    logic [1:0] idx;
    w_pick  = r_last;
    w_found = 1'b0;
    idx     = r_last;
    for (int k = 1; k <= 4; k++) begin
      idx = r_last + 2'(k);
      if (!w_found && req[idx]) begin
        w_pick  = idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_last_nxt     = r_last;
    w_grant_nxt    = r_grant;
    w_busy_nxt     = r_busy;
    w_timeout_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
        if (w_found) begin
          w_state_nxt    = S_GRANT;
          w_sel_nxt      = w_pick;
          w_grant_nxt    = 4'b0001 << w_pick;
          w_busy_nxt     = 1'b1;
          w_last_nxt     = w_pick;
          w_hold_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (done || !req[r_sel]) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 4'b0000;
          w_busy_nxt  = 1'b0;
        end else if (c_TO_EN && (r_hold_cnt == c_HOLD_LAST)) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
          // Saturates when the timeout is disabled so the counter never wraps.
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 2'b00;
      r_last     <= 2'd3;
      r_grant    <= 4'b0000;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_last     <= w_last_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_sel_arbiter: vector table plus corner sequences, MAX_HOLD = 4.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rr_sel_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       to;
  } out_t;

  typedef struct {
    logic [3:0] req;
    logic       done;
    out_t       exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic out_t oexp(logic [1:0] s, logic [3:0] g, logic b, logic t);
    out_t o;
    o.sel = s; o.grant = g; o.busy = b; o.to = t;
    return o;
  endfunction

  function automatic vec_t mk(logic [3:0] r, logic d, out_t e, string nm);
    vec_t v;
    v.req = r; v.done = d; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input out_t e);
    n_chk++;
    if (sel !== e.sel || grant !== e.grant || busy !== e.busy || timeout !== e.to) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d grant=%b busy=%b timeout=%b, expected sel=%0d grant=%b busy=%b timeout=%b",
               nm, sel, grant, busy, timeout, e.sel, e.grant, e.busy, e.to);
    end
    n_chk++;
    if (!(grant == 4'b0000 || $onehot(grant)) || (busy && !grant[sel])) begin
      n_fail++;
      $display("FAIL %s_invariant: got grant=%b busy=%b sel=%0d, required one-hot/zero grant with grant[sel] when busy",
               nm, grant, busy, sel);
    end
  endtask

  // Drive one cycle of inputs, queue its expected result, compare after the edge.
  task automatic step(input logic [3:0] r, input logic d, input out_t e, input string nm);
    req  = r;
    done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(nm, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rotation from reset (last=3, so ch0 first), done two cycles after each grant.
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "rot_g0"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "rot_h0"));
    vecs.push_back(mk(4'hF, 1'b1, oexp(2'd0, 4'b0000, 1'b0, 1'b0), "rot_r0"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd1, 4'b0010, 1'b1, 1'b0), "rot_g1"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd1, 4'b0010, 1'b1, 1'b0), "rot_h1"));
    vecs.push_back(mk(4'hF, 1'b1, oexp(2'd1, 4'b0000, 1'b0, 1'b0), "rot_r1"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "rot_g2"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "rot_h2"));
    vecs.push_back(mk(4'hF, 1'b1, oexp(2'd2, 4'b0000, 1'b0, 1'b0), "rot_r2"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd3, 4'b1000, 1'b1, 1'b0), "rot_g3"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd3, 4'b1000, 1'b1, 1'b0), "rot_h3"));
    vecs.push_back(mk(4'hF, 1'b1, oexp(2'd3, 4'b0000, 1'b0, 1'b0), "rot_r3"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "rot_g0b"));
    vecs.push_back(mk(4'hF, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "rot_h0b"));
    vecs.push_back(mk(4'hF, 1'b1, oexp(2'd0, 4'b0000, 1'b0, 1'b0), "rot_r0b"));
    // Bring last to 2, then req=0011 must wrap to ch0, then ch1.
    vecs.push_back(mk(4'h6, 1'b0, oexp(2'd1, 4'b0010, 1'b1, 1'b0), "pre_g1"));
    vecs.push_back(mk(4'h6, 1'b1, oexp(2'd1, 4'b0000, 1'b0, 1'b0), "pre_r1"));
    vecs.push_back(mk(4'h6, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "pre_g2"));
    vecs.push_back(mk(4'h6, 1'b1, oexp(2'd2, 4'b0000, 1'b0, 1'b0), "pre_r2"));
    vecs.push_back(mk(4'h3, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "wrap_g0"));
    vecs.push_back(mk(4'h3, 1'b1, oexp(2'd0, 4'b0000, 1'b0, 1'b0), "wrap_r0"));
    vecs.push_back(mk(4'h3, 1'b0, oexp(2'd1, 4'b0010, 1'b1, 1'b0), "wrap_g1"));
    // Withdraw req[1] during the ch1 grant.
    vecs.push_back(mk(4'h1, 1'b0, oexp(2'd1, 4'b0000, 1'b0, 1'b0), "withdraw"));
    // Timeout: held exactly 4 cycles, pulse on release, regrant after one idle.
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "to_g"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "to_h1"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "to_h2"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "to_h3"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0000, 1'b0, 1'b1), "to_pulse"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "to_regrant"));
    // done on the final hold cycle wins over timeout.
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "col_h1"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "col_h2"));
    vecs.push_back(mk(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "col_h3"));
    vecs.push_back(mk(4'h4, 1'b1, oexp(2'd2, 4'b0000, 1'b0, 1'b0), "col_done"));
    // ch3 grant ahead of the idle-stability run.
    vecs.push_back(mk(4'h8, 1'b0, oexp(2'd3, 4'b1000, 1'b1, 1'b0), "idle_g3"));
    vecs.push_back(mk(4'h8, 1'b1, oexp(2'd3, 4'b0000, 1'b0, 1'b0), "idle_r3"));

    rst  = 1'b1;
    req  = 4'h0;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", oexp(2'd0, 4'b0000, 1'b0, 1'b0));
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i].req, vecs[i].done, vecs[i].exp, vecs[i].name);

    for (int i = 0; i < 20; i++)
      step(4'h0, (i == 10), oexp(2'd3, 4'b0000, 1'b0, 1'b0), "idle_stable");

    // Asynchronous reset mid-grant, away from any clock edge.
    step(4'h4, 1'b0, oexp(2'd2, 4'b0100, 1'b1, 1'b0), "rst_pre_grant");
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", oexp(2'd0, 4'b0000, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'hF, 1'b0, oexp(2'd0, 4'b0001, 1'b1, 1'b0), "rst_first_grant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
